// File: rtl/sram_fill_ctrl_if.sv
// rtl/sram_fill_ctrl_if.sv - pipeline request and SRAM pin bundle for sram_fill_ctrl
interface sram_fill_ctrl_if;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        cache_hit;
   logic        pause;
   logic        fill_valid;
   logic [63:0] fill_data;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;
   logic        sram_oe_n;

   modport slave (
      input  MEM_R_EN, MEM_W_EN, address, writeData, cache_hit, sram_dq_in,
      output pause, fill_valid, fill_data, sram_addr, sram_dq_out, sram_dq_oe,
             sram_we_n, sram_oe_n
   );

   modport master (
      output MEM_R_EN, MEM_W_EN, address, writeData, cache_hit, sram_dq_in,
      input  pause, fill_valid, fill_data, sram_addr, sram_dq_out, sram_dq_oe,
             sram_we_n, sram_oe_n
   );
endinterface

// File: rtl/sram_fill_ctrl.sv
// rtl/sram_fill_ctrl.sv - cache line fill and word store sequencer for a 16-bit SRAM
// A miss reads four halfwords into a 64-bit line; a store writes two halfwords.
module sram_fill_ctrl #(
   parameter int ACC_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   sram_fill_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
   localparam logic [3:0] LAST = 4'(ACC_CYCLES - 1);

   state_t      state;
   logic [3:0]  acc_cnt;
   logic [1:0]  hw_cnt;
   logic [16:0] addr_lat;   // address[18:2]; a read line uses addr_lat[16:1]
   logic [15:0] wdata_hi;
   logic        fill_valid_r;
   logic [63:0] fill_data_r;
   logic [17:0] sram_addr_r;
   logic [15:0] dq_out_r;
   logic        dq_oe_r;
   logic        we_n_r;
   logic        oe_n_r;
   logic        rd_miss;
   logic        access_end;
   logic        unused_addr_bits;

   assign rd_miss          = bus.MEM_R_EN && !bus.cache_hit;
   assign access_end       = (acc_cnt == LAST);
   assign unused_addr_bits = &{1'b0, bus.address[31:19], bus.address[1:0]};

   assign bus.pause       = (rd_miss || bus.MEM_W_EN) && (state != DONE);
   assign bus.fill_valid  = fill_valid_r;
   assign bus.fill_data   = fill_data_r;
   assign bus.sram_addr   = sram_addr_r;
   assign bus.sram_dq_out = dq_out_r;
   assign bus.sram_dq_oe  = dq_oe_r;
   assign bus.sram_we_n   = we_n_r;
   assign bus.sram_oe_n   = oe_n_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         acc_cnt      <= '0;
         hw_cnt       <= '0;
         addr_lat     <= '0;
         wdata_hi     <= '0;
         fill_valid_r <= 1'b0;
         fill_data_r  <= '0;
         sram_addr_r  <= '0;
         dq_out_r     <= '0;
         dq_oe_r      <= 1'b0;
         we_n_r       <= 1'b1;
         oe_n_r       <= 1'b1;
      end else begin
         fill_valid_r <= 1'b0;
         case (state)
            IDLE: begin
               acc_cnt <= '0;
               hw_cnt  <= '0;
               if (rd_miss) begin
                  state       <= READ;
                  addr_lat    <= bus.address[18:2];
                  sram_addr_r <= {bus.address[18:3], 2'b00};
                  oe_n_r      <= 1'b0;
               end else if (bus.MEM_W_EN) begin
                  state       <= WRITE;
                  addr_lat    <= bus.address[18:2];
                  wdata_hi    <= bus.writeData[31:16];
                  sram_addr_r <= {bus.address[18:2], 1'b0};
                  dq_out_r    <= bus.writeData[15:0];
                  dq_oe_r     <= 1'b1;
                  we_n_r      <= 1'b0;
               end
            end
            READ: begin
               if (access_end) begin
                  // Sample on the last cycle of the access so the SRAM has settled.
                  fill_data_r[{hw_cnt, 4'd0} +: 16] <= bus.sram_dq_in;
                  acc_cnt <= '0;
                  hw_cnt  <= hw_cnt + 2'd1;
                  if (hw_cnt == 2'd3) begin
                     state        <= DONE;
                     oe_n_r       <= 1'b1;
                     fill_valid_r <= 1'b1;
                  end else begin
                     sram_addr_r <= {addr_lat[16:1], hw_cnt + 2'd1};
                  end
               end else begin
                  acc_cnt <= acc_cnt + 4'd1;
               end
            end
            WRITE: begin
               if (access_end) begin
                  acc_cnt <= '0;
                  if (hw_cnt[0]) begin
                     state   <= DONE;
                     dq_oe_r <= 1'b0;
                     we_n_r  <= 1'b1;
                  end else begin
                     hw_cnt      <= 2'd1;
                     sram_addr_r <= {addr_lat, 1'b1};
                     dq_out_r    <= wdata_hi;
                     we_n_r      <= 1'b0;
                  end
               end else begin
                  // Release the write strobe one cycle before the access ends for hold time.
                  acc_cnt <= acc_cnt + 4'd1;
                  we_n_r  <= (acc_cnt + 4'd1 == LAST);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sram_fill_ctrl.sv
// tb/tb_sram_fill_ctrl.sv - randomized self-checking bench for sram_fill_ctrl
// Instance 0 runs ACC_CYCLES=2, instance 1 runs ACC_CYCLES=3.
module tb_sram_fill_ctrl;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   logic        mem_r_en      [2];
   logic        mem_w_en      [2];
   logic        cache_hit     [2];
   logic [31:0] address       [2];
   logic [31:0] write_data    [2];
   logic        pause_o       [2];
   logic        fill_valid_o  [2];
   logic [63:0] fill_data_o   [2];
   logic [17:0] sram_addr_o   [2];
   logic [15:0] sram_dq_out_o [2];
   logic        sram_dq_oe_o  [2];
   logic        sram_we_n_o   [2];
   logic        sram_oe_n_o   [2];

   logic [15:0] sram_mem [1024];
   logic [63:0] exp_fill [2];
   logic [17:0] exp_hold [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sram_fill_ctrl_if bus ();
      sram_fill_ctrl #(.ACC_CYCLES(g + 2)) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );
      assign bus.MEM_R_EN   = mem_r_en[g];
      assign bus.MEM_W_EN   = mem_w_en[g];
      assign bus.cache_hit  = cache_hit[g];
      assign bus.address    = address[g];
      assign bus.writeData  = write_data[g];
      assign bus.sram_dq_in = sram_mem[bus.sram_addr[9:0]];
      assign pause_o[g]       = bus.pause;
      assign fill_valid_o[g]  = bus.fill_valid;
      assign fill_data_o[g]   = bus.fill_data;
      assign sram_addr_o[g]   = bus.sram_addr;
      assign sram_dq_out_o[g] = bus.sram_dq_out;
      assign sram_dq_oe_o[g]  = bus.sram_dq_oe;
      assign sram_we_n_o[g]   = bus.sram_we_n;
      assign sram_oe_n_o[g]   = bus.sram_oe_n;
   end

   // Halfword addresses: a line is four consecutive halfwords, a store is two.
   function automatic logic [17:0] rd_addr(input logic [31:0] a, input int hw);
      return 18'((int'(a[18:0]) / 8) * 4 + hw);
   endfunction

   function automatic logic [17:0] wr_addr(input logic [31:0] a, input int hw);
      return 18'((int'(a[18:0]) / 4) * 2 + hw);
   endfunction

   // {sram_addr, oe_n, we_n, dq_oe, fill_valid, pause}
   function automatic logic [22:0] obs(input int d);
      return {sram_addr_o[d], sram_oe_n_o[d], sram_we_n_o[d], sram_dq_oe_o[d],
              fill_valid_o[d], pause_o[d]};
   endfunction

   task automatic quiet_other(input int d);
      mem_r_en[1-d] = 1'b0;
      mem_w_en[1-d] = 1'b0;
   endtask

   task automatic idle_cycles(input int d, input int n, input logic r_en, input logic hit);
      logic [22:0] exp_v;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         quiet_other(d);
         mem_r_en[d]   = r_en;
         mem_w_en[d]   = 1'b0;
         cache_hit[d]  = hit;
         address[d]    = $urandom;
         write_data[d] = $urandom;
         #1;
         exp_v = {exp_hold[d], 4'b1100, 1'b0};
         n_cmp++;
         if (obs(d) !== exp_v) begin
            n_bad++;
            $display("FAIL idle d=%0d k=%0d: got %h, want %h", d, k, obs(d), exp_v);
         end
         n_cmp++;
         if (fill_data_o[d] !== exp_fill[d]) begin
            n_bad++;
            $display("FAIL fill_hold_idle d=%0d: got %h, want %h", d, fill_data_o[d], exp_fill[d]);
         end
      end
   endtask

   task automatic do_read(input int d, input logic [31:0] a, input logic with_w,
                          input logic idle_after);
      int          acc;
      logic [63:0] exp_line;
      logic [17:0] ea;
      logic [22:0] exp_v;
      acc = d + 2;
      for (int h = 0; h < 4; h++) begin
         ea = rd_addr(a, h);
         exp_line[16*h +: 16] = sram_mem[ea[9:0]];
      end
      for (int k = 0; k <= 4*acc + 1; k++) begin
         @(negedge clk);
         quiet_other(d);
         if (k == 0) begin
            mem_r_en[d]  = 1'b1;
            mem_w_en[d]  = with_w;
            cache_hit[d] = 1'b0;
            address[d]   = a;
         end else begin
            address[d] = $urandom;
         end
         write_data[d] = $urandom;
         #1;
         if (k == 0)
            exp_v = {exp_hold[d], 4'b1100, 1'b1};
         else if (k <= 4*acc)
            exp_v = {rd_addr(a, (k - 1) / acc), 4'b0100, 1'b1};
         else
            exp_v = {rd_addr(a, 3), 4'b1101, 1'b0};
         n_cmp++;
         if (obs(d) !== exp_v) begin
            n_bad++;
            $display("FAIL read d=%0d k=%0d: got %h, want %h", d, k, obs(d), exp_v);
         end
      end
      n_cmp++;
      if (fill_data_o[d] !== exp_line) begin
         n_bad++;
         $display("FAIL fill_data d=%0d: got %h, want %h", d, fill_data_o[d], exp_line);
      end
      exp_fill[d] = exp_line;
      exp_hold[d] = rd_addr(a, 3);
      if (idle_after) idle_cycles(d, 1, 1'b0, 1'b0);
   endtask

   task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic idle_after);
      int          acc;
      int          hw;
      int          pos;
      logic [22:0] exp_v;
      logic [15:0] exp_dq;
      acc = d + 2;
      for (int k = 0; k <= 2*acc + 1; k++) begin
         @(negedge clk);
         quiet_other(d);
         if (k == 0) begin
            mem_r_en[d]   = 1'b0;
            mem_w_en[d]   = 1'b1;
            cache_hit[d]  = 1'b0;
            address[d]    = a;
            write_data[d] = wd;
         end else begin
            address[d]    = $urandom;
            write_data[d] = $urandom;
            cache_hit[d]  = 1'($urandom);
         end
         #1;
         if (k == 0) begin
            exp_v = {exp_hold[d], 4'b1100, 1'b1};
         end else if (k <= 2*acc) begin
            hw     = (k - 1) / acc;
            pos    = (k - 1) % acc;
            exp_v  = {wr_addr(a, hw), 1'b1, (pos == acc - 1), 2'b10, 1'b1};
            exp_dq = (hw != 0) ? wd[31:16] : wd[15:0];
            n_cmp++;
            if (sram_dq_out_o[d] !== exp_dq) begin
               n_bad++;
               $display("FAIL dq_out d=%0d k=%0d: got %h, want %h", d, k, sram_dq_out_o[d], exp_dq);
            end
         end else begin
            exp_v = {wr_addr(a, 1), 4'b1100, 1'b0};
         end
         n_cmp++;
         if (obs(d) !== exp_v) begin
            n_bad++;
            $display("FAIL write d=%0d k=%0d: got %h, want %h", d, k, obs(d), exp_v);
         end
      end
      n_cmp++;
      if (fill_data_o[d] !== exp_fill[d]) begin
         n_bad++;
         $display("FAIL fill_hold_write d=%0d: got %h, want %h", d, fill_data_o[d], exp_fill[d]);
      end
      exp_hold[d] = wr_addr(a, 1);
      if (idle_after) idle_cycles(d, 1, 1'b0, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if (obs(d) !== {18'd0, 4'b1100, 1'b0}) begin
            n_bad++;
            $display("FAIL %s d=%0d: got %h, want %h", tag, d, obs(d), {18'd0, 4'b1100, 1'b0});
         end
         n_cmp++;
         if (fill_data_o[d] !== 64'd0 || sram_dq_out_o[d] !== 16'd0) begin
            n_bad++;
            $display("FAIL %s_data d=%0d: got fill %h dq %h, want 0", tag, d, fill_data_o[d], sram_dq_out_o[d]);
         end
         exp_fill[d] = '0;
         exp_hold[d] = '0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         mem_r_en[d]   = 1'b0;
         mem_w_en[d]   = 1'b0;
         cache_hit[d]  = 1'b0;
         address[d]    = '0;
         write_data[d] = '0;
      end
      @(posedge clk);
      #1;
      check_reset_values("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_cycles(0, 2, 1'b0, 1'b0);
   endtask

   task automatic test_read_miss;
      sram_mem[10'h094] = 16'h1111;
      sram_mem[10'h095] = 16'h2222;
      sram_mem[10'h096] = 16'h3333;
      sram_mem[10'h097] = 16'h4444;
      do_read(0, 32'h0000_0128, 1'b0, 1'b0);
      n_cmp++;
      if (fill_data_o[0] !== 64'h4444_3333_2222_1111) begin
         n_bad++;
         $display("FAIL directed_line: got %h, want %h", fill_data_o[0], 64'h4444_3333_2222_1111);
      end
      idle_cycles(0, 1, 1'b0, 1'b0);
      do_read(0, $urandom, 1'b0, 1'b1);
   endtask

   task automatic test_write;
      do_write(0, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1);
      do_write(0, $urandom, $urandom, 1'b1);
   endtask

   task automatic test_read_hit;
      idle_cycles(0, 4, 1'b1, 1'b1);
      do_read(0, $urandom, 1'b0, 1'b1);
   endtask

   task automatic test_rw_priority;
      do_read(0, $urandom, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid_read;
      logic [31:0] a;
      a = $urandom;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         quiet_other(0);
         if (k == 0) begin
            mem_r_en[0]  = 1'b1;
            cache_hit[0] = 1'b0;
            address[0]   = a;
         end
      end
      #1;
      n_cmp++;
      if (sram_addr_o[0] !== rd_addr(a, 2)) begin
         n_bad++;
         $display("FAIL pre_reset_addr: got %h, want %h", sram_addr_o[0], rd_addr(a, 2));
      end
      #1;
      mem_r_en[0] = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_values("async_reset");
      #1;
      rst = 1'b0;
      idle_cycles(0, 10, 1'b0, 1'b0);
      do_read(0, $urandom, 1'b0, 1'b1);
   endtask

   task automatic test_acc3;
      do_read(1, $urandom, 1'b0, 1'b1);
      do_write(1, $urandom, $urandom, 1'b1);
      idle_cycles(1, 2, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back;
      for (int d = 0; d < 2; d++) begin
         do_read(d, $urandom, 1'b0, 1'b0);
         do_write(d, $urandom, $urandom, 1'b0);
         do_read(d, $urandom, 1'b0, 1'b1);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 40; i++) begin
         int d;
         int op;
         d  = $urandom_range(0, 1);
         op = $urandom_range(0, 3);
         case (op)
            0:       do_read(d, $urandom, 1'b0, 1'($urandom));
            1:       do_write(d, $urandom, $urandom, 1'($urandom));
            2:       idle_cycles(d, $urandom_range(1, 3), 1'b1, 1'b1);
            default: do_read(d, $urandom, 1'b1, 1'($urandom));
         endcase
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      for (int i = 0; i < 1024; i++) sram_mem[i] = 16'($urandom);
      test_reset;
      test_read_miss;
      test_write;
      test_read_hit;
      test_rw_priority;
      test_reset_mid_read;
      test_acc3;
      test_back_to_back;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
